// File: rtl/bp_fe_realigner_buffer.sv
// Parcel-granular fetch realignment buffer: 16-bit parcels in a circular store, one instruction out per handshake.
// Optional compressed-instruction support is enabled by defining BP_FE_REALIGNER_RVC_EN.
module bp_fe_realigner_buffer #(
   parameter int vaddr_width_p    = 39,
   parameter int fetch_width_p    = 64,
   parameter int buffer_parcels_p = 8
) (
   input  logic                                  clk_i,
   input  logic                                  reset_n_i,
   input  logic                                  fetch_v_i,
   output logic                                  fetch_ready_o,
   input  logic [vaddr_width_p-1:0]              fetch_pc_i,
   input  logic [fetch_width_p-1:0]              fetch_data_i,
   input  logic                                  redirect_v_i,
   input  logic                                  redirect_resume_i,
   input  logic [15:0]                           redirect_partial_i,
   input  logic [vaddr_width_p-1:0]              redirect_vaddr_i,
   output logic                                  instr_v_o,
   output logic [vaddr_width_p-1:0]              instr_pc_o,
   output logic [31:0]                           instr_o,
   output logic                                  instr_compressed_o,
   input  logic                                  instr_yumi_i,
   output logic                                  partial_o,
   output logic [$clog2(buffer_parcels_p+1)-1:0] count_o
);
   localparam int fetch_parcels_lp = fetch_width_p / 16;
   localparam int ptr_width_lp     = $clog2(buffer_parcels_p);
   localparam int cnt_width_lp     = $clog2(buffer_parcels_p + 1);
   localparam int off_width_lp     = $clog2(fetch_parcels_lp);

   logic                     rst_meta_q, rst_sync_q;
   logic [15:0]              buf_q    [buffer_parcels_p];
   logic [15:0]              buf_d    [buffer_parcels_p];
   logic [ptr_width_lp-1:0]  head_q, head_d, tail_q, tail_d, wr_idx_s;
   logic [cnt_width_lp-1:0]  count_q, count_d, enq_amt_s, pop_amt_s;
   logic [vaddr_width_p-1:0] head_pc_q, head_pc_d;
   logic                     pc_valid_q, pc_valid_d;
   logic [off_width_lp-1:0]  offset_s;
   logic [15:0]              head_parcel_s, next_parcel_s;
   logic                     compressed_s, instr_v_s, accept_s, pop_s;

   // Reset asserts asynchronously but is released on a clock edge
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rst_meta_q <= 1'b0;
         rst_sync_q <= 1'b0;
      end else begin
         rst_meta_q <= 1'b1;
         rst_sync_q <= rst_meta_q;
      end
   end

   assign head_parcel_s = buf_q[head_q];
   assign next_parcel_s = buf_q[head_q + ptr_width_lp'(1)];
   assign offset_s      = fetch_pc_i[off_width_lp:1];

`ifdef BP_FE_REALIGNER_RVC_EN
   assign compressed_s = (count_q != cnt_width_lp'(0)) && (head_parcel_s[1:0] != 2'b11);
`else
   assign compressed_s = 1'b0;
`endif

   assign instr_v_s = (count_q >= cnt_width_lp'(2)) | compressed_s;
   assign fetch_ready_o = ~redirect_v_i &
      ((cnt_width_lp'(buffer_parcels_p) - count_q) >= cnt_width_lp'(fetch_parcels_lp));
   assign accept_s  = fetch_v_i & fetch_ready_o;
   assign pop_s     = instr_yumi_i & instr_v_s;
   assign enq_amt_s = cnt_width_lp'(fetch_parcels_lp) - cnt_width_lp'(offset_s);
   assign pop_amt_s = compressed_s ? cnt_width_lp'(1) : cnt_width_lp'(2);

   assign instr_v_o          = instr_v_s;
   assign instr_pc_o         = head_pc_q;
   assign instr_o            = !instr_v_s   ? 32'h0000_0000 :
                               compressed_s ? {16'h0000, head_parcel_s} :
                                              {next_parcel_s, head_parcel_s};
   assign instr_compressed_o = compressed_s;
   assign partial_o          = (count_q == cnt_width_lp'(1)) & ~compressed_s;
   assign count_o            = count_q;

   // Next-state: redirect overrides everything, otherwise enqueue and dequeue combine
   always_comb begin
      buf_d      = buf_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      head_pc_d  = head_pc_q;
      pc_valid_d = pc_valid_q;
      wr_idx_s   = tail_q;
      if (redirect_v_i) begin
         head_d = '0;
         if (redirect_resume_i) begin
            buf_d[0]   = redirect_partial_i;
            tail_d     = ptr_width_lp'(1);
            count_d    = cnt_width_lp'(1);
            head_pc_d  = redirect_vaddr_i - vaddr_width_p'(2);
            pc_valid_d = 1'b1;
         end else begin
            tail_d     = '0;
            count_d    = '0;
            pc_valid_d = 1'b0;
         end
      end else begin
         if (accept_s) begin
            for (int i = 0; i < fetch_parcels_lp; i++) begin
               wr_idx_s = tail_q + ptr_width_lp'(i) - ptr_width_lp'(offset_s);
               if (i >= int'(offset_s)) begin
                  buf_d[wr_idx_s] = fetch_data_i[16*i +: 16];
               end else begin
                  buf_d[wr_idx_s] = buf_q[wr_idx_s];
               end
            end
            tail_d = tail_q + ptr_width_lp'(enq_amt_s);
            // An empty buffer with no known PC adopts the PC of the incoming block
            if ((count_q == cnt_width_lp'(0)) && !pc_valid_q) begin
               head_pc_d  = fetch_pc_i & ~vaddr_width_p'(1);
               pc_valid_d = 1'b1;
            end else begin
               head_pc_d  = head_pc_q;
               pc_valid_d = pc_valid_q;
            end
         end else begin
            tail_d = tail_q;
         end
         if (pop_s) begin
            head_d    = head_q + ptr_width_lp'(pop_amt_s);
            head_pc_d = head_pc_q + vaddr_width_p'({pop_amt_s, 1'b0});
         end else begin
            head_d = head_q;
         end
         count_d = count_q + (accept_s ? enq_amt_s : cnt_width_lp'(0))
                           - (pop_s ? pop_amt_s : cnt_width_lp'(0));
      end
   end

   // Buffer state registers
   always_ff @(posedge clk_i or negedge rst_sync_q) begin
      if (!rst_sync_q) begin
         for (int i = 0; i < buffer_parcels_p; i++) begin
            buf_q[i] <= 16'h0000;
         end
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         head_pc_q  <= '0;
         pc_valid_q <= 1'b0;
      end else begin
         for (int i = 0; i < buffer_parcels_p; i++) begin
            buf_q[i] <= buf_d[i];
         end
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         head_pc_q  <= head_pc_d;
         pc_valid_q <= pc_valid_d;
      end
   end

   bp_fe_realigner_buffer_chk u_chk (
      .clk_i        (clk_i),
      .rst_n_i      (rst_sync_q),
      .instr_v_i    (instr_v_s),
      .instr_yumi_i (instr_yumi_i)
   );
endmodule

// Protocol checks on the consumer handshake.
module bp_fe_realigner_buffer_chk (
   input logic clk_i,
   input logic rst_n_i,
   input logic instr_v_i,
   input logic instr_yumi_i
);
   a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!rst_n_i)
      instr_yumi_i |-> instr_v_i);
endmodule

// File: tb/tb_bp_fe_realigner_buffer.sv
// Directed self-checking bench for bp_fe_realigner_buffer (default configuration, 4-parcel blocks, 8-parcel buffer).
module tb_bp_fe_realigner_buffer;
   logic        clk_i = 1'b0;
   logic        reset_n_i;
   logic        fetch_v_i;
   logic        fetch_ready_o;
   logic [38:0] fetch_pc_i;
   logic [63:0] fetch_data_i;
   logic        redirect_v_i;
   logic        redirect_resume_i;
   logic [15:0] redirect_partial_i;
   logic [38:0] redirect_vaddr_i;
   logic        instr_v_o;
   logic [38:0] instr_pc_o;
   logic [31:0] instr_o;
   logic        instr_compressed_o;
   logic        instr_yumi_i;
   logic        partial_o;
   logic [3:0]  count_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   bp_fe_realigner_buffer dut (
      .clk_i              (clk_i),
      .reset_n_i          (reset_n_i),
      .fetch_v_i          (fetch_v_i),
      .fetch_ready_o      (fetch_ready_o),
      .fetch_pc_i         (fetch_pc_i),
      .fetch_data_i       (fetch_data_i),
      .redirect_v_i       (redirect_v_i),
      .redirect_resume_i  (redirect_resume_i),
      .redirect_partial_i (redirect_partial_i),
      .redirect_vaddr_i   (redirect_vaddr_i),
      .instr_v_o          (instr_v_o),
      .instr_pc_o         (instr_pc_o),
      .instr_o            (instr_o),
      .instr_compressed_o (instr_compressed_o),
      .instr_yumi_i       (instr_yumi_i),
      .partial_o          (partial_o),
      .count_o            (count_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      fetch_v_i         = 1'b0;
      instr_yumi_i      = 1'b0;
      redirect_v_i      = 1'b0;
      redirect_resume_i = 1'b0;
   endtask

   task automatic fetch(input logic [38:0] pc, input logic [63:0] data);
      fetch_v_i    = 1'b1;
      fetch_pc_i   = pc;
      fetch_data_i = data;
      tick();
      fetch_v_i    = 1'b0;
   endtask

   task automatic pop();
      instr_yumi_i = 1'b1;
      tick();
      instr_yumi_i = 1'b0;
   endtask

   task automatic expect_instr(input string tag, input logic [31:0] ins, input logic [38:0] pc,
                               input logic [3:0] cnt);
      chk({tag, "_v"}, 64'(instr_v_o), 64'd1);
      chk({tag, "_instr"}, 64'(instr_o), 64'(ins));
      chk({tag, "_pc"}, 64'(instr_pc_o), 64'(pc));
      chk({tag, "_count"}, 64'(count_o), 64'(cnt));
   endtask

   task automatic expect_reset_outputs(input string tag);
      chk({tag, "_v"}, 64'(instr_v_o), 64'd0);
      chk({tag, "_partial"}, 64'(partial_o), 64'd0);
      chk({tag, "_count"}, 64'(count_o), 64'd0);
      chk({tag, "_ready"}, 64'(fetch_ready_o), 64'd1);
      chk({tag, "_instr"}, 64'(instr_o), 64'd0);
      chk({tag, "_pc"}, 64'(instr_pc_o), 64'd0);
   endtask

   initial begin
      reset_n_i          = 1'b0;
      fetch_pc_i         = '0;
      fetch_data_i       = '0;
      redirect_partial_i = '0;
      redirect_vaddr_i   = '0;
      idle_inputs();
      tick();
      tick();
      expect_reset_outputs("rst");
      reset_n_i = 1'b1;
      tick();
      tick();
      tick();

`ifdef BP_FE_REALIGNER_RVC_EN
      fetch(39'h4000, 64'h0000_0003_ABCD_4501);
      expect_instr("rvc0", 32'h0000_4501, 39'h4000, 4'd4);
      chk("rvc0_c", 64'(instr_compressed_o), 64'd1);
      pop();
      expect_instr("rvc1", 32'h0000_ABCD, 39'h4002, 4'd3);
      chk("rvc1_c", 64'(instr_compressed_o), 64'd1);
      pop();
      expect_instr("rvc2", 32'h0000_0003, 39'h4004, 4'd2);
      chk("rvc2_c", 64'(instr_compressed_o), 64'd0);
      pop();
      chk("rvc_empty", 64'(count_o), 64'd0);
`else
      // Aligned stream with back-to-back fetches filling the buffer
      fetch(39'h1000, 64'h2222_2222_1111_1111);
      expect_instr("al0", 32'h1111_1111, 39'h1000, 4'd4);
      chk("al0_c", 64'(instr_compressed_o), 64'd0);
      fetch(39'h1008, 64'h4444_4444_3333_3333);
      chk("full_count", 64'(count_o), 64'd8);
      chk("full_ready", 64'(fetch_ready_o), 64'd0);
      pop();
      expect_instr("al1", 32'h2222_2222, 39'h1004, 4'd6);
      chk("two_free_ready", 64'(fetch_ready_o), 64'd0);
      pop();
      expect_instr("al2", 32'h3333_3333, 39'h1008, 4'd4);
      chk("four_free_ready", 64'(fetch_ready_o), 64'd1);
      // Simultaneous accept and pop, with tail wrapping
      fetch_v_i    = 1'b1;
      fetch_pc_i   = 39'h1010;
      fetch_data_i = 64'h6666_6666_5555_5555;
      instr_yumi_i = 1'b1;
      tick();
      idle_inputs();
      expect_instr("both", 32'h4444_4444, 39'h100C, 4'd6);
      pop();
      expect_instr("al4", 32'h5555_5555, 39'h1010, 4'd4);
      pop();
      expect_instr("al5", 32'h6666_6666, 39'h1014, 4'd2);
      pop();
      chk("drain_count", 64'(count_o), 64'd0);
      chk("drain_v", 64'(instr_v_o), 64'd0);

      // Flush: redirect beats same-cycle fetch and yumi
      fetch(39'h1018, 64'h8888_8888_7777_7777);
      expect_instr("seq", 32'h7777_7777, 39'h1018, 4'd4);
      redirect_v_i = 1'b1;
      instr_yumi_i = 1'b1;
      fetch_v_i    = 1'b1;
      fetch_pc_i   = 39'h1020;
      #1;
      chk("redir_ready", 64'(fetch_ready_o), 64'd0);
      tick();
      idle_inputs();
      chk("flush_count", 64'(count_o), 64'd0);
      chk("flush_v", 64'(instr_v_o), 64'd0);
      chk("flush_partial", 64'(partial_o), 64'd0);
      fetch(39'h3000, 64'hAAAA_5555_1234_5678);
      expect_instr("newpc", 32'h1234_5678, 39'h3000, 4'd4);

      // Misaligned start spanning two blocks
      redirect_v_i = 1'b1;
      tick();
      idle_inputs();
      fetch(39'h1006, 64'hBBBB_0000_0000_0000);
      chk("mis_count", 64'(count_o), 64'd1);
      chk("mis_partial", 64'(partial_o), 64'd1);
      chk("mis_v", 64'(instr_v_o), 64'd0);
      fetch(39'h1008, 64'h0000_0000_0000_AAAA);
      expect_instr("mis", 32'hAAAA_BBBB, 39'h1006, 4'd5);
      chk("mis_partial2", 64'(partial_o), 64'd0);

      // Asynchronous reset between clock edges
      #3;
      reset_n_i = 1'b0;
      #1;
      expect_reset_outputs("arst");
      tick();
      reset_n_i = 1'b1;
      tick();
      tick();
      tick();
      expect_reset_outputs("arst_rel");

      // Redirect with resume of a partial parcel
      fetch(39'h1002, 64'h0003_0002_0001_FFFF);
      chk("res_pre_count", 64'(count_o), 64'd3);
      redirect_v_i       = 1'b1;
      redirect_resume_i  = 1'b1;
      redirect_partial_i = 16'h0CCC;
      redirect_vaddr_i   = 39'h2002;
      fetch_v_i          = 1'b1;
      fetch_pc_i         = 39'h5000;
      fetch_data_i       = 64'h1111_1111_1111_1111;
      tick();
      idle_inputs();
      chk("res_count", 64'(count_o), 64'd1);
      chk("res_partial", 64'(partial_o), 64'd1);
      chk("res_v", 64'(instr_v_o), 64'd0);
      chk("res_pc", 64'(instr_pc_o), 64'h2000);
      fetch(39'h2002, 64'h0000_0000_DDDD_0000);
      expect_instr("res", 32'hDDDD_0CCC, 39'h2000, 4'd4);
      pop();
      expect_instr("res_next", 32'h0000_0000, 39'h2004, 4'd2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/bp_fe_realigner_buffer.md
Name: bp_fe_realigner_buffer

Overview:
- Parcel-granular fetch realignment buffer between I$ data output and FE instruction queue; successor to single-half-buffer realigner.
- Accepts fetch blocks of fetch_width_p bits starting at any 16-bit-aligned PC, stores 16-bit parcels in a circular buffer, emits one 32-bit instruction per handshake regardless of block boundaries.
- Supports backend redirect with optional partial-instruction resume.

Parameters:
- vaddr_width_p, 39, virtual address width.
- fetch_width_p, 64, fetch block width in bits; multiple of 32; fetch_parcels = fetch_width_p/16.
- buffer_parcels_p, 8, buffer depth in parcels; power of 2, >= 2*fetch_parcels.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- fetch_v_i  in  1  fetch block valid.
- fetch_ready_o  out  1  buffer can accept a whole block.
- fetch_pc_i  in  vaddr_width_p  PC of first useful parcel (bit 0 ignored).
- fetch_data_i  in  fetch_width_p  block data, block-aligned, parcel 0 in LSBs.
- redirect_v_i  in  1  backend redirect.
- redirect_resume_i  in  1  with redirect_v_i: restore one partial parcel.
- redirect_partial_i  in  16  lower half of interrupted instruction.
- redirect_vaddr_i  in  vaddr_width_p  PC following restored parcel.
- instr_v_o  out  1  instruction valid.
- instr_pc_o  out  vaddr_width_p  instruction PC.
- instr_o  out  32  instruction bits.
- instr_compressed_o  out  1  instr_o is 16-bit (upper 16 zero).
- instr_yumi_i  in  1  consumer takes instruction; only when instr_v_o.
- partial_o  out  1  exactly one parcel held, waiting for upper half.
- count_o  out  $clog2(buffer_parcels_p+1)  parcels held.

Behaviour:
- Reset (async assert, sync deassert internally): head/tail ptr=0, count=0, head_pc=0, pc_valid=0; outputs: instr_v_o=0, partial_o=0, count_o=0, fetch_ready_o=1, instr_o/pc don't-care but driven 0.
- Enqueue: accept = fetch_v_i & fetch_ready_o. fetch_ready_o = ~redirect_v_i & (buffer_parcels_p - count >= fetch_parcels), computed on pre-pop count (same-cycle pop not credited).
- Parcels written: offset = fetch_pc_i[log2(fetch_width_p/8)-1:1]; parcels offset..fetch_parcels-1 appended at tail, count += fetch_parcels-offset. Tail wraps modulo buffer_parcels_p.
- If count==0 and pc_valid==0 at accept, head_pc <= fetch_pc_i, pc_valid<=1. Otherwise fetch_pc_i assumed sequential; not checked.
- Dequeue (RVC off): instr_v_o = count>=2; instr_o = {parcel[head+1], parcel[head]} (wrap-aware); instr_pc_o=head_pc. On yumi: head+=2, count-=2, head_pc+=4 (mod 2^vaddr_width_p).
- partial_o = (count==1).
- Same-cycle accept and yumi: both applied; count updated by net delta.
- Zero-latency output: registered parcels visible combinationally the cycle after write; no data bypass from fetch_data_i.
- Redirect (redirect_v_i=1) wins over same-cycle accept and yumi (both ignored). resume=0: count=0, head=tail=0, pc_valid=0. resume=1: buffer holds only redirect_partial_i at parcel 0, count=1, tail=1, head_pc=redirect_vaddr_i-2, pc_valid=1.
- Yumi while instr_v_o=0 is illegal (assertion).

Optional Feature:
- BP_FE_REALIGNER_RVC_EN. Defined: if parcel[head][1:0]!=2'b11, instruction is compressed: instr_v_o=count>=1, instr_o={16'b0,parcel[head]}, instr_compressed_o=1, yumi pops 1, head_pc+=2; partial_o=(count==1)&(parcel[head][1:0]==2'b11). Undefined: all instructions 32-bit, instr_compressed_o tied 0.

Test Plan:
- Aligned stream: fetches pc=0x1000 data=0x2222_2222_1111_1111, then pc=0x1008 -> instrs 0x1111_1111@0x1000, 0x2222_2222@0x1004, then 0x1008 instrs, count_o back to 0.
- Misaligned start: pc=0x1006 data upper parcel 0xBBBB -> count_o=1, partial_o=1, instr_v_o=0; next fetch pc=0x1008 low parcel 0xAAAA -> instr_o=0xAAAA_BBBB, pc 0x1006.
- Full/backpressure: yumi held 0, depth 8, fetch_parcels 4 -> two fetches accepted, fetch_ready_o=0 with count_o=8; one yumi -> still 0 (6 free<4? no: 2 free) until two yumis -> ready=1.
- Redirect resume: count_o=3, redirect resume partial=0x0CCC vaddr=0x2002, same-cycle fetch_v_i -> fetch ignored, count_o=1, partial_o=1; fetch pc=0x2002 parcel 0xDDDD -> instr 0xDDDD_0CCC @0x2000.
- Flush: redirect without resume plus yumi same cycle -> count_o=0, instr_v_o=0; next fetch pc=0x3000 sets head_pc=0x3000.
- Async reset mid-stream (count_o=5): assert reset_n_i low between edges -> outputs immediately at reset values; with RVC_EN, parcel 0x4501 emitted as compressed @+2 step.
